// File: rtl/seq_counter_pkg.sv
// rtl/seq_counter_pkg.sv - shared constants for the sequencing counter
package seq_counter_pkg;

  // Terminal behaviour selected by the MODE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Encoding of the dir input
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/seq_counter_if.sv
// rtl/seq_counter_if.sv - control and status bundle of the sequencing counter
interface seq_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             start;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output en, clr, load, load_val, dir, start,
    input  count, tc, busy, done
  );

  modport slave (
    input  en, clr, load, load_val, dir, start,
    output count, tc, busy, done
  );

endinterface

// File: rtl/seq_counter_ff.sv
// rtl/seq_counter_ff.sv - enabled flop cell with asynchronous active-high reset to zero
module seq_counter_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Capture d when enabled; reset clears without waiting for a clock edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/seq_counter_next.sv
// rtl/seq_counter_next.sv - combinational step value and terminal detect
module seq_counter_next
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = (1 << WIDTH) - 1,
  parameter int MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             busy_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             at_terminal_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam bit               SAT   = (MODE == MODE_SAT);

  // A run always counts up and parks on MAX; idle stepping follows dir and MODE.
  // Counts above MAX (from a parallel load) are treated as already past terminal.
  always_comb begin
    next_count_o  = count_i;
    at_terminal_o = 1'b0;
    if (busy_i) begin
      at_terminal_o = (count_i == MAX_V);
      next_count_o  = (count_i < MAX_V) ? count_i + ONE_V : MAX_V;
    end else if (dir_i == DIR_UP) begin
      at_terminal_o = (count_i == MAX_V);
      if (count_i >= MAX_V) begin
        next_count_o = SAT ? MAX_V : '0;
      end else begin
        next_count_o = count_i + ONE_V;
      end
    end else begin
      at_terminal_o = (count_i == '0);
      if (count_i == '0) begin
        next_count_o = SAT ? '0 : MAX_V;
      end else begin
        next_count_o = count_i - ONE_V;
      end
    end
  end

endmodule

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - parametrised up/down counter with one-shot run mode
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = (1 << WIDTH) - 1,
  parameter int MODE  = MODE_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  seq_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d, step_count;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             count_we, busy_we;
  logic             at_term;

  seq_counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .MODE  (MODE)
  ) u_next (
    .count_i       (count_q),
    .dir_i         (bus.dir),
    .busy_i        (busy_q),
    .next_count_o  (step_count),
    .at_terminal_o (at_term)
  );

  // Edge priority clr > load > start > en; load and start only act while idle,
  // and done is a one-edge pulse raised when an enabled run step finds MAX.
  always_comb begin
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    count_we = 1'b0;
    busy_we  = 1'b0;
    if (bus.clr) begin
      count_d  = '0;
      busy_d   = 1'b0;
      count_we = 1'b1;
      busy_we  = 1'b1;
    end else if (bus.load && !busy_q) begin
      count_d  = bus.load_val;
      count_we = 1'b1;
    end else if (bus.start && !busy_q) begin
      count_d  = '0;
      busy_d   = 1'b1;
      count_we = 1'b1;
      busy_we  = 1'b1;
    end else if (bus.en) begin
      count_d  = step_count;
      count_we = 1'b1;
      if (busy_q && at_term) begin
        busy_d  = 1'b0;
        busy_we = 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  seq_counter_ff #(.WIDTH(WIDTH)) u_count_ff (
    .clk_i (clk), .rst_i (reset), .en_i (count_we), .d_i (count_d), .q_o (count_q)
  );

  seq_counter_ff #(.WIDTH(1)) u_busy_ff (
    .clk_i (clk), .rst_i (reset), .en_i (busy_we), .d_i (busy_d), .q_o (busy_q)
  );

  seq_counter_ff #(.WIDTH(1)) u_done_ff (
    .clk_i (clk), .rst_i (reset), .en_i (1'b1), .d_i (done_d), .q_o (done_q)
  );

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.tc    = at_term;

endmodule
